shot_clock_display: RTL and testbench

SHOT_CLOCK_DISPLAY -- requirements
Module: shot_clock_display

---
 rtl/shot_clock_display_if.sv | 30 +++
 rtl/shot_clock_display.sv | 209 ++++++++++++++++++++
 tb/tb_shot_clock_display.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shot_clock_display_if.sv
// Shot-clock display bus: the two BCD digits and expiry flag coming from the
// shot-clock core, and the multiplexed 7-segment / buzzer drive going out.
//   timerH  4  BCD tens digit (asynchronous to the display clock)
//   timerL  4  BCD units digit (asynchronous to the display clock)
//   alarm   1  shot-clock expiry flag (asynchronous to the display clock)
//   seg     7  segments {g,f,e,d,c,b,a}, active-high
//   dig     2  digit enables, active-low; dig[1] tens, dig[0] units
//   buzzer  1  buzzer drive, active-high
//   err     1  accepted value holds a non-BCD digit
// master: source of digits/alarm (shot-clock core or bench)
// slave : the display controller
interface shot_clock_display_if;
   logic [3:0] timerH;
   logic [3:0] timerL;
   logic       alarm;
   logic [6:0] seg;
   logic [1:0] dig;
   logic       buzzer;
   logic       err;

   modport master (
      output timerH, timerL, alarm,
      input  seg, dig, buzzer, err
   );

   modport slave (
      input  timerH, timerL, alarm,
      output seg, dig, buzzer, err
   );
endinterface

// File: rtl/shot_clock_display.sv
// Two-digit multiplexed shot-clock display with low-time blink and a
// pulsed expiry buzzer.
//   cp     display clock, all state on the rising edge
//   nrest  asynchronous active-low reset
//   bus    shot_clock_display_if.slave (timerH/timerL/alarm in;
//          seg/dig/buzzer/err out, all outputs registered)
//
// Buzzer sequencer
//   state  | meaning
//   S_IDLE | quiet, waiting for a rising edge of the synchronized alarm
//   S_ON   | buzzer driven, on-time down-counter running
//   S_OFF  | gap between pulses, off-time down-counter running
//   S_DONE | all pulses given, waiting for alarm to drop before re-arming
module shot_clock_display #(
   parameter int SCAN_DIV   = 1000,
   parameter int BLINK_DIV  = 25000,
   parameter int BEEP_ON    = 5000,
   parameter int BEEP_OFF   = 5000,
   parameter int BEEP_COUNT = 3
) (
   input logic                 cp,
   input logic                 nrest,
   shot_clock_display_if.slave bus
);

   localparam int SW      = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int BMAX    = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
   localparam int TW      = (BMAX > 1) ? $clog2(BMAX) : 1;
   localparam int PW      = $clog2(BEEP_COUNT + 1);
   localparam int ON_LD   = (BEEP_ON  > 0) ? BEEP_ON  - 1 : 0;
   localparam int OFF_LD  = (BEEP_OFF > 0) ? BEEP_OFF - 1 : 0;

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} beep_state_t;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h40;
      endcase
   endfunction

   logic [7:0]    raw_s1, raw_s2, raw_prev, acc_q, acc_nx;
   logic          alarm_s1, alarm_s2, alarm_d;
   logic [SW-1:0] scan_cnt;
   logic          scan_wrap, started_q, started_nx, sel_q, sel_nx;
   logic [BW-1:0] blink_cnt;
   logic          blink_wrap, phase_q, phase_nx;
   logic [3:0]    digit_h, digit_l;
   logic          blank;
   logic [6:0]    seg_nx, seg_q;
   logic [1:0]    dig_nx, dig_q;
   logic          err_q, buzzer_q;
   beep_state_t   state_q, state_nx;
   logic [TW-1:0] tmr_q, tmr_nx;
   logic [PW-1:0] pcnt_q, pcnt_nx;
   logic          alarm_rise;

   // A value is taken only after it has been seen twice in a row, which
   // filters out the skew between the two asynchronously changing digits.
   assign acc_nx = (raw_s2 == raw_prev) ? raw_s2 : acc_q;

   always_ff @(posedge cp or negedge nrest) begin
      if (!nrest) begin
         raw_s1   <= '0;
         raw_s2   <= '0;
         raw_prev <= '0;
         acc_q    <= '0;
         alarm_s1 <= 1'b0;
         alarm_s2 <= 1'b0;
         alarm_d  <= 1'b0;
      end else begin
         raw_s1   <= {bus.timerH, bus.timerL};
         raw_s2   <= raw_s1;
         raw_prev <= raw_s2;
         acc_q    <= acc_nx;
         alarm_s1 <= bus.alarm;
         alarm_s2 <= alarm_s1;
         alarm_d  <= alarm_s2;
      end
   end

   // Digits stay dark until the first wrap; that first wrap lights units
   // without toggling, every later wrap alternates units/tens.
   assign scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
   assign started_nx = started_q | scan_wrap;
   assign sel_nx     = (scan_wrap && started_q) ? ~sel_q : sel_q;

   assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
   assign phase_nx   = phase_q ^ blink_wrap;

   always_ff @(posedge cp or negedge nrest) begin
      if (!nrest) begin
         scan_cnt  <= '0;
         started_q <= 1'b0;
         sel_q     <= 1'b0;
         blink_cnt <= '0;
         phase_q   <= 1'b0;
      end else begin
         scan_cnt  <= scan_wrap ? '0 : scan_cnt + SW'(1);
         started_q <= started_nx;
         sel_q     <= sel_nx;
         blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
         phase_q   <= phase_nx;
      end
   end

   // Output registers are fed from next-state values so seg/dig/err all
   // describe the same cycle.
   assign digit_h = acc_nx[7:4];
   assign digit_l = acc_nx[3:0];
   assign blank   = phase_nx && (digit_h == 4'd0) &&
                    (digit_l != 4'd0) && (digit_l <= 4'd5);

   always_comb begin
      seg_nx = 7'h00;
      dig_nx = 2'b11;
      if (started_nx) begin
         if (sel_nx) begin
            dig_nx = 2'b01;
            if (!blank && (digit_h != 4'd0)) seg_nx = seg7(digit_h);
         end else begin
            dig_nx = 2'b10;
            if (!blank) seg_nx = seg7(digit_l);
         end
      end
   end

   assign alarm_rise = alarm_s2 & ~alarm_d;

   always_comb begin
      state_nx = state_q;
      tmr_nx   = tmr_q;
      pcnt_nx  = pcnt_q;
      case (state_q)
         S_IDLE: begin
            if (alarm_rise) begin
               state_nx = S_ON;
               tmr_nx   = TW'(ON_LD);
               pcnt_nx  = PW'(1);
            end
         end
         S_ON: begin
            if (!alarm_s2) begin
               state_nx = S_IDLE;
            end else if (tmr_q == '0) begin
               if (pcnt_q < PW'(BEEP_COUNT)) begin
                  state_nx = S_OFF;
                  tmr_nx   = TW'(OFF_LD);
               end else begin
                  state_nx = S_DONE;
               end
            end else begin
               tmr_nx = tmr_q - TW'(1);
            end
         end
         S_OFF: begin
            if (!alarm_s2) begin
               state_nx = S_IDLE;
            end else if (tmr_q == '0) begin
               state_nx = S_ON;
               tmr_nx   = TW'(ON_LD);
               pcnt_nx  = pcnt_q + PW'(1);
            end else begin
               tmr_nx = tmr_q - TW'(1);
            end
         end
         S_DONE: begin
            if (!alarm_s2) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge cp or negedge nrest) begin
      if (!nrest) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         pcnt_q   <= '0;
         seg_q    <= 7'h00;
         dig_q    <= 2'b11;
         err_q    <= 1'b0;
         buzzer_q <= 1'b0;
      end else begin
         state_q  <= state_nx;
         tmr_q    <= tmr_nx;
         pcnt_q   <= pcnt_nx;
         seg_q    <= seg_nx;
         dig_q    <= dig_nx;
         err_q    <= (digit_h > 4'd9) || (digit_l > 4'd9);
         buzzer_q <= (state_nx == S_ON);
      end
   end

   assign bus.seg    = seg_q;
   assign bus.dig    = dig_q;
   assign bus.err    = err_q;
   assign bus.buzzer = buzzer_q;

endmodule

// File: tb/tb_shot_clock_display.sv
module tb_shot_clock_display;
   localparam int SCAN  = 4;
   localparam int BLINK = 16;
   localparam int BON   = 3;
   localparam int BOFF  = 2;
   localparam int BCNT  = 3;

   logic cp = 1'b0;
   logic nrest = 1'b0;

   shot_clock_display_if bus();

   shot_clock_display #(
      .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .BEEP_ON(BON),
      .BEEP_OFF(BOFF), .BEEP_COUNT(BCNT)
   ) dut (
      .cp(cp),
      .nrest(nrest),
      .bus(bus)
   );

   always #5 cp = ~cp;

   int nchk = 0;
   int nerr = 0;

   // Reference model: k = rising edges since reset release; v0..v3 and
   // a0..a3 are the inputs seen at edges k, k-1, k-2, k-3.
   int         k;
   logic [7:0] v0, v1, v2, v3, acc_m;
   logic       a0, a1, a2, a3, active;
   int         t0;
   logic [6:0] e_seg;
   logic [1:0] e_dig;
   logic       e_buz, e_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] code(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   task automatic model_reset();
      k = 0; t0 = 0; active = 1'b0; acc_m = 8'h00;
      v0 = 0; v1 = 0; v2 = 0; v3 = 0;
      a0 = 0; a1 = 0; a2 = 0; a3 = 0;
   endtask

   task automatic model_edge();
      int  w, d, per;
      logic off, blink;
      k++;
      v3 = v2; v2 = v1; v1 = v0; v0 = {bus.timerH, bus.timerL};
      a3 = a2; a2 = a1; a1 = a0; a0 = bus.alarm;
      // stable for two consecutive samples, two-flop synchronizer delay
      if (v2 == v3) acc_m = v2;
      // alarm as seen after synchronization: a2 now, a3 one cycle before
      if (a2 && !a3) begin active = 1'b1; t0 = k; end
      else if (!a2) active = 1'b0;
      per = BON + BOFF;
      d = k - t0;
      e_buz = active && (d < BCNT * per - BOFF) && ((d % per) < BON);
      e_err = (acc_m[7:4] > 9) || (acc_m[3:0] > 9);
      w = k / SCAN;
      off = ((k / BLINK) % 2) == 1;
      blink = off && (acc_m[7:4] == 0) && (acc_m[3:0] >= 1) && (acc_m[3:0] <= 5);
      if (w == 0) begin
         e_dig = 2'b11; e_seg = 7'h00;
      end else if (((w - 1) % 2) == 0) begin
         e_dig = 2'b10; e_seg = blink ? 7'h00 : code(acc_m[3:0]);
      end else begin
         e_dig = 2'b01;
         e_seg = (blink || acc_m[7:4] == 0) ? 7'h00 : code(acc_m[7:4]);
      end
   endtask

   // One cycle: wait for the edge, sample 1 time unit later, advance model,
   // compare every output.
   task automatic step();
      @(posedge cp);
      #1;
      if (!nrest) begin
         model_reset();
         e_seg = 7'h00; e_dig = 2'b11; e_buz = 1'b0; e_err = 1'b0;
      end else begin
         model_edge();
      end
      chk("seg", {25'd0, bus.seg}, {25'd0, e_seg});
      chk("dig", {30'd0, bus.dig}, {30'd0, e_dig});
      chk("buzzer", {31'd0, bus.buzzer}, {31'd0, e_buz});
      chk("err", {31'd0, bus.err}, {31'd0, e_err});
   endtask

   task automatic setv(input logic [7:0] v);
      bus.timerH = v[7:4];
      bus.timerL = v[3:0];
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [17:0] cap18;
      logic [4:0]  cap5;
      logic [2:0]  cap3;
      int          cnt_on, cnt_off, ones;
      logic        found;
      logic [7:0]  rv;

      model_reset();
      setv(8'h24);
      bus.alarm = 1'b0;
      nrest = 1'b0;
      run(3);

      // steady 24: units 66 / tens 5B
      nrest = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 2)  chk("lit_dark_before_wrap", {30'd0, bus.dig}, 32'h3);
         if (i == 13) begin
            chk("lit_units_seg24", {25'd0, bus.seg}, 32'h66);
            chk("lit_units_dig", {30'd0, bus.dig}, 32'h2);
         end
         if (i == 17) begin
            chk("lit_tens_seg24", {25'd0, bus.seg}, 32'h5B);
            chk("lit_tens_dig", {30'd0, bus.dig}, 32'h1);
         end
      end

      // 03 blinks: on window k=32..47, off window k=48..63
      nrest = 1'b0;
      setv(8'h03);
      run(2);
      nrest = 1'b1;
      cnt_on = 0; cnt_off = 0;
      for (int i = 1; i <= 64; i++) begin
         step();
         if (i >= 32 && i <= 47 && bus.dig == 2'b10 && bus.seg == 7'h4F) cnt_on++;
         if (i >= 48 && i <= 63 && bus.dig == 2'b10 && bus.seg == 7'h00) cnt_off++;
      end
      chk("lit_blink_on_units", cnt_on, 8);
      chk("lit_blink_off_units", cnt_off, 8);

      // full beep sequence on 00
      setv(8'h00);
      run(6);
      bus.alarm = 1'b1;
      for (int i = 17; i >= 0; i--) begin
         step();
         cap18[i] = bus.buzzer;
      end
      chk("lit_beep_pattern", {14'd0, cap18}, {14'd0, 18'b001110011100111000});
      run(20);
      bus.alarm = 1'b0;
      run(5);
      bus.alarm = 1'b1;
      for (int i = 4; i >= 0; i--) begin
         step();
         cap5[i] = bus.buzzer;
      end
      chk("lit_beep_retrigger", {27'd0, cap5}, {27'd0, 5'b00111});

      // drop alarm inside the second pulse
      run(2);
      bus.alarm = 1'b0;
      for (int i = 2; i >= 0; i--) begin
         step();
         cap3[i] = bus.buzzer;
      end
      chk("lit_beep_abort", {29'd0, cap3}, {29'd0, 3'b110});
      run(6);
      bus.alarm = 1'b1;
      for (int i = 17; i >= 0; i--) begin
         step();
         cap18[i] = bus.buzzer;
      end
      chk("lit_beep_restart", {14'd0, cap18}, {14'd0, 18'b001110011100111000});
      bus.alarm = 1'b0;
      run(4);

      // non-BCD units digit and a one-cycle glitch
      setv(8'h0A);
      run(8);
      chk("lit_err_nonbcd", {31'd0, bus.err}, 32'h1);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         step();
         if (bus.dig == 2'b10) begin
            found = 1'b1;
            chk("lit_dash_units", {25'd0, bus.seg}, 32'h40);
         end
      end
      chk("units_slot_found", {31'd0, found}, 32'h1);
      setv(8'h24);
      step();
      setv(8'h0A);
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.err) ones++;
      end
      chk("lit_glitch_ignored", ones, 8);

      // reset in the middle of a beep
      setv(8'h00);
      bus.alarm = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (bus.buzzer) found = 1'b1;
      end
      chk("beep_started", {31'd0, found}, 32'h1);
      #3 nrest = 1'b0;
      #1;
      chk("lit_rst_buzzer", {31'd0, bus.buzzer}, 32'h0);
      chk("lit_rst_dig", {30'd0, bus.dig}, 32'h3);
      chk("lit_rst_seg", {25'd0, bus.seg}, 32'h0);
      bus.alarm = 1'b0;
      run(2);
      nrest = 1'b1;
      ones = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.buzzer) ones++;
      end
      chk("lit_no_beep_after_rst", ones, 0);

      // alarm already high at reset release
      nrest = 1'b0;
      bus.alarm = 1'b1;
      run(2);
      nrest = 1'b1;
      for (int i = 4; i >= 0; i--) begin
         step();
         cap5[i] = bus.buzzer;
      end
      chk("lit_alarm_at_release", {27'd0, cap5}, {27'd0, 5'b00111});

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 4) == 0) rv = 8'($urandom);
         else rv = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
         setv(rv);
         if ($urandom_range(0, 3) == 0) bus.alarm = ~bus.alarm;
         run($urandom_range(1, 12));
         if ($urandom_range(0, 5) == 0) begin
            setv(8'($urandom));
            step();
            setv(rv);
         end
         if ($urandom_range(0, 60) == 0) begin
            #3 nrest = 1'b0;
            step();
            step();
            nrest = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
